qam_demapper: RTL and testbench



---
 rtl/qam_demapper.sv | 177 +++++++++++++++++
 tb/tb_qam_demapper.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_demapper.sv
// qam_demapper: hard-decision BPSK/QPSK/16-QAM demapper.
// Slices packed {Q,I} samples into decision bits and serialises them MSB-first
// over a valid/ready bit stream, one bit per cycle with no gap between symbols.
// Optional build macro QAM_DEMAP_STATS_EN adds the sym_count accepted-symbol counter.
module qam_demapper #(
  parameter int IQ_W   = 16,
  parameter int THRESH = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [2*IQ_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              busy
`ifdef QAM_DEMAP_STATS_EN
  ,
  output logic [31:0]       sym_count
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0]      MODE_QPSK  = 2'd1;
  localparam logic [1:0]      MODE_QAM16 = 2'd2;
  localparam logic [IQ_W-1:0] THRESH_U   = IQ_W'(THRESH);
  localparam logic [IQ_W-1:0] MOST_NEG   = {1'b1, {(IQ_W-1){1'b0}}};
  localparam logic [IQ_W-1:0] MAX_POS    = {1'b0, {(IQ_W-1){1'b1}}};
  localparam logic [IQ_W-1:0] ONE        = IQ_W'(1);

  state_t          state_q, state_d;
  logic [3:0]      shift_q, shift_d;
  logic [2:0]      count_q, count_d;
  logic            ready_en_q, ready_en_d;

  logic [IQ_W-1:0] i_val;
  logic [IQ_W-1:0] q_val;
  logic            i_sign, q_sign, i_mag, q_mag;
  logic [3:0]      dec_bits;
  logic [2:0]      dec_n;
  logic            load;

  // Magnitude decision: |x| >= THRESH, with the most-negative code saturating
  // to the largest positive value so its negation cannot overflow.
  function automatic logic mag_bit(input logic [IQ_W-1:0] x);
    logic [IQ_W-1:0] a;
    if (x == MOST_NEG) begin
      a = MAX_POS;
    end else if (x[IQ_W-1]) begin
      a = ~x + ONE;
    end else begin
      a = x;
    end
    return (a >= THRESH_U);
  endfunction

  // Slice the presented sample into left-aligned decision bits and a bit count
  // for the currently selected mode; only used when the sample is accepted.
  always_comb begin
    i_val    = sample_in[IQ_W-1:0];
    q_val    = sample_in[2*IQ_W-1:IQ_W];
    i_sign   = i_val[IQ_W-1];
    q_sign   = q_val[IQ_W-1];
    i_mag    = mag_bit(i_val);
    q_mag    = mag_bit(q_val);
    dec_bits = {i_sign, 3'b000};
    dec_n    = 3'd1;
    case (mode)
      MODE_QPSK: begin
        dec_bits = {i_sign, q_sign, 2'b00};
        dec_n    = 3'd2;
      end
      MODE_QAM16: begin
        dec_bits = {i_sign, i_mag, q_sign, q_mag};
        dec_n    = 3'd4;
      end
      default: begin
        dec_bits = {i_sign, 3'b000};
        dec_n    = 3'd1;
      end
    endcase
  end

  // Next-state and handshake logic: accept in IDLE, shift out in SHIFT, and
  // hand straight over to a waiting sample when the final bit is taken.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    ready_en_d   = 1'b1;
    sample_ready = 1'b0;
    bit_valid    = 1'b0;
    busy         = 1'b0;
    bit_out      = shift_q[3];
    load         = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready = enable && ready_en_q;
        if (sample_valid && sample_ready) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        bit_valid = 1'b1;
        busy      = 1'b1;
        if (bit_ready) begin
          if (count_q == 3'd1) begin
            sample_ready = enable && sample_valid;
            if (sample_ready) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              count_d = 3'd0;
            end
          end else begin
            shift_d = {shift_q[2:0], 1'b0};
            count_d = count_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      shift_d = dec_bits;
      count_d = dec_n;
      state_d = SHIFT;
    end
  end

  // State, shift register, bit counter and the post-reset ready gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 4'b0000;
      count_q    <= 3'd0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
    end
  end

`ifdef QAM_DEMAP_STATS_EN
  logic [31:0] sym_count_q, sym_count_d;

  // Accepted-symbol counter, wrapping naturally at 32 bits.
  always_comb begin
    sym_count_d = sym_count_q;
    if (load) begin
      sym_count_d = sym_count_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_count_q <= 32'd0;
    end else begin
      sym_count_q <= sym_count_d;
    end
  end

  assign sym_count = sym_count_q;
`endif

endmodule

// File: tb/tb_qam_demapper.sv
// Scoreboard testbench for qam_demapper: directed scenarios plus randomized
// traffic checked against a behavioural slicing model.
module tb_qam_demapper;

  localparam int IQ_W   = 16;
  localparam int THRESH = 2048;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
`ifdef QAM_DEMAP_STATS_EN
  logic [31:0] sym_count;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   exp_q[$];
  int   exp_sym  = 0;
  logic last_acc = 1'b0;
  logic last_hs  = 1'b0;
  int   br_mode  = 0;
  int   br_phase = 0;

  qam_demapper #(.IQ_W(IQ_W), .THRESH(THRESH)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mode(mode),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .busy(busy)
`ifdef QAM_DEMAP_STATS_EN
    ,
    .sym_count(sym_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Saturating absolute value of a signed component.
  function automatic int sat_abs(input int x);
    int a;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    return a;
  endfunction

  // Reference model: decision bits straight from the constellation rules.
  function automatic void push_expected(input logic [1:0] md, input int i, input int q);
    bit si, sq, mi, mq;
    si = (i < 0);
    sq = (q < 0);
    mi = (sat_abs(i) >= THRESH);
    mq = (sat_abs(q) >= THRESH);
    case (md)
      2'd1: begin exp_q.push_back(si); exp_q.push_back(sq); end
      2'd2: begin exp_q.push_back(si); exp_q.push_back(mi); exp_q.push_back(sq); exp_q.push_back(mq); end
      default: exp_q.push_back(si);
    endcase
  endfunction

  function automatic logic next_br();
    logic b;
    case (br_mode)
      1: begin b = ((br_phase % 3) == 0); br_phase++; end
      2: b = ($urandom_range(0, 3) != 0);
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  function automatic int rand_comp();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 2048;
      2: return -2048;
      3: return 2047;
      4: return -2049;
      5: return -32768;
      6: return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // One cycle of stimulus: drive on negedge, observe handshakes 1 unit later.
  task automatic applyStimulus(input logic r, input logic en, input logic v, input logic [1:0] md,
                               input int i, input int q, input logic br);
    @(negedge clk);
    rst          = r;
    enable       = en;
    sample_valid = v;
    mode         = md;
    sample_in    = {16'(q), 16'(i)};
    bit_ready    = br;
    #1;
    last_hs  = bit_valid && bit_ready && !rst;
    last_acc = sample_valid && sample_ready && !rst;
    if (last_acc) begin
      push_expected(md, i, q);
      exp_sym++;
    end
    if (rst) begin
      exp_q.delete();
      exp_sym = 0;
    end
  endtask

  task automatic send(input logic [1:0] md, input int i, input int q);
    for (int k = 0; k < 64; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, md, i, q, next_br());
      if (last_acc) break;
    end
    check("send_accepted", last_acc, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 64; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, next_br());
      if (!busy && !bit_valid) break;
    end
    check("drain_idle", busy, 0);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: pop the scoreboard on every bit handshake and check stall stability.
  task automatic checkOutput();
    logic stall;
    logic held;
    stall = 1'b0;
    held  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid_held", bit_valid, 1);
          check("stall_bit_held", bit_out, held);
        end
        if (bit_valid && bit_ready) begin
          if (exp_q.size() == 0) check("bit_unexpected", 1, 0);
          else check("bit_value", bit_out, exp_q.pop_front());
        end
        stall = bit_valid && !bit_ready;
        held  = bit_out;
      end
    end
  endtask

  initial checkOutput();

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nb;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; sample_in = '0; sample_valid = 1'b0; bit_ready = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sample_ready", sample_ready, 0);
    check("rst_bit_out", bit_out, 0);
`ifdef QAM_DEMAP_STATS_EN
    check("rst_sym_count", sym_count, 0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("post_rst_ready", sample_ready, 1);

    // BPSK: +3 then -3
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 3, 0, 1'b1);
    check("bpsk_acc1", last_acc, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, -3, 0, 1'b1);
    check("bpsk_latency", bit_valid, 1);
    check("bpsk_acc2", last_acc, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("bpsk_bit2_valid", bit_valid, 1);
    check("bpsk_no_acc", last_acc, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("bpsk_idle", bit_valid, 0);
    check("bpsk_ready_back", sample_ready, 1);

    // QPSK back-to-back
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, -100, 100, 1'b1);
    check("qpsk_acc1", last_acc, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 0, -1, 1'b1);
    check("qpsk_ready_mid", sample_ready, 0);
    check("qpsk_valid_c2", bit_valid, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 0, -1, 1'b1);
    check("qpsk_acc2_handover", last_acc, 1);
    check("qpsk_valid_c3", bit_valid, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 1'b1);
    check("qpsk_no_gap", bit_valid, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 1'b1);
    check("qpsk_valid_c5", bit_valid, 1);
    drain();

    // 16-QAM with saturation and equality cases
    send(2'd2, 3000, -500);
    send(2'd2, -32768, 2048);
    drain();

    // Backpressure: bit_ready pattern 1,0,0,...
    br_mode = 1; br_phase = 0;
    send(2'd2, -3000, 100);
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 100, -100, next_br());
      if (last_acc) begin
        check("bp_accept_on_last_bit", nb, 3);
        check("bp_accept_with_handshake", last_hs, 1);
        break;
      end
      check("bp_ready_low", sample_ready, 0);
      if (last_hs) nb++;
    end
    check("bp_second_accepted", last_acc, 1);
    drain();
    br_mode = 0;

    // Mode change and enable low during a 16-QAM symbol
    send(2'd2, -5000, 5000);
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 7, 7, 1'b1);
      check("en_off_no_accept", last_acc, 0);
      if (last_hs) nb++;
    end
    check("en_off_bits", nb, 4);
    check("en_off_idle", busy, 0);
    send(2'd0, -1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("reenable_one_bit", bit_valid, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("reenable_done", bit_valid, 0);
    drain();

    // Reset mid-symbol after 2 of 4 bits
    send(2'd2, -3000, -3000);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("midrst_bit_valid", bit_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", sample_ready, 0);
`ifdef QAM_DEMAP_STATS_EN
    check("midrst_sym_count", sym_count, 0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1);
    check("midrst_ready_next", sample_ready, 1);
    send(2'd0, 5, 0);
    send(2'd1, -5, 9);
    send(2'd3, -9, -9);
    drain();
`ifdef QAM_DEMAP_STATS_EN
    check("sym_count_three", sym_count, 3);
`endif

    // Randomized traffic
    br_mode = 2;
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                    2'($urandom_range(0, 3)), rand_comp(), rand_comp(), next_br());
    end
    br_mode = 0;
    drain();
`ifdef QAM_DEMAP_STATS_EN
    check("sym_count_random", sym_count, exp_sym);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
